// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP multiplier among NUM_REQ requesters.
// Optional FP_MUL_ARB_PERF_EN adds perf_ops / perf_busy_cycles counters.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_data,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           mul_a,
    output logic                  mul_a_stb,
    input  logic                  mul_a_ack,
    output logic [31:0]           mul_b,
    output logic                  mul_b_stb,
    input  logic                  mul_b_ack,
    input  logic [31:0]           mul_prod,
    input  logic                  mul_prod_stb,
    output logic                  mul_prod_ack,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  busy
`ifdef FP_MUL_ARB_PERF_EN
    ,
    output logic [31:0]           perf_ops,
    output logic [31:0]           perf_busy_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_WAIT_RES,
        ST_DELIVER
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [31:0]          mul_a_q, mul_a_d;
    logic [31:0]          mul_b_q, mul_b_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 mul_a_stb_q, mul_a_stb_d;
    logic                 mul_b_stb_q, mul_b_stb_d;
    logic                 mul_prod_ack_q, mul_prod_ack_d;
    logic                 busy_q, busy_d;

    logic [31:0]          a_arr [NUM_REQ];
    logic [31:0]          b_arr [NUM_REQ];
    logic                 found;
    logic [IDX_W-1:0]     win_idx;
    logic                 deliver_done;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[32*g +: 32];
        assign b_arr[g] = req_b[32*g +: 32];
    end

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        win_idx = rr_ptr_q;
        for (int off = 1; off <= NUM_REQ; off++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(rr_ptr_q) + off) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign deliver_done = (state_q == ST_DELIVER) && rsp_ready[grant_q];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_d        = grant_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        rsp_data_d     = rsp_data_q;
        req_ready_d    = '0;
        rsp_valid_d    = rsp_valid_q;
        mul_a_stb_d    = mul_a_stb_q;
        mul_b_stb_d    = mul_b_stb_q;
        mul_prod_ack_d = mul_prod_ack_q;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d              = ST_SEND_A;
                    rr_ptr_d             = win_idx;
                    grant_d              = win_idx;
                    mul_a_d              = a_arr[win_idx];
                    mul_b_d              = b_arr[win_idx];
                    req_ready_d[win_idx] = 1'b1;
                    mul_a_stb_d          = 1'b1;
                end
            end
            ST_SEND_A: begin
                if (mul_a_stb_q && mul_a_ack) begin
                    mul_a_stb_d = 1'b0;
                    mul_b_stb_d = 1'b1;
                    state_d     = ST_SEND_B;
                end
            end
            ST_SEND_B: begin
                if (mul_b_stb_q && mul_b_ack) begin
                    mul_b_stb_d    = 1'b0;
                    mul_prod_ack_d = 1'b1;
                    state_d        = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (mul_prod_stb && mul_prod_ack_q) begin
                    rsp_data_d           = mul_prod;
                    mul_prod_ack_d       = 1'b0;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (deliver_done) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered busy mirrors the next state, so it is high exactly outside IDLE.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= IDX_W'(NUM_REQ - 1);
            grant_q        <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            rsp_data_q     <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            mul_a_stb_q    <= 1'b0;
            mul_b_stb_q    <= 1'b0;
            mul_prod_ack_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_q        <= grant_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            rsp_data_q     <= rsp_data_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            mul_a_stb_q    <= mul_a_stb_d;
            mul_b_stb_q    <= mul_b_stb_d;
            mul_prod_ack_q <= mul_prod_ack_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign mul_a        = mul_a_q;
    assign mul_a_stb    = mul_a_stb_q;
    assign mul_b        = mul_b_q;
    assign mul_b_stb    = mul_b_stb_q;
    assign mul_prod_ack = mul_prod_ack_q;
    assign grant_idx    = grant_q;
    assign busy         = busy_q;

`ifdef FP_MUL_ARB_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_ops_d  = perf_ops_q;
        perf_busy_d = perf_busy_q;
        if (deliver_done) perf_ops_d = perf_ops_q + 32'd1;
        if (busy_q)       perf_busy_d = perf_busy_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_ops_q  <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_ops         = perf_ops_q;
    assign perf_busy_cycles = perf_busy_q;
`endif

endmodule
